collisions_n: RTL and testbench

- Parametrised successor to the two-snake collision logic: judges one game step for N_SNAKES snakes.
- Sequential design. On each start pulse it snapshots the next-state snake geometry. It then scans the map one snake per cycle through a registered tile-read port, and resolves per-snake eaten/died plus a global won/draw result.
- Sits between the snake movement logic and the game FSM, clocked on the game step clock.

---
 rtl/collisions_n.sv | 271 +++++++++++++++++++++++++++
 tb/tb_collisions_n.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/collisions_n.sv
// collisions_n: judges one game step for N_SNAKES snakes. A start pulse
// snapshots the next-state geometry. The block then reads the tile under each
// snake's head, one snake per cycle, and resolves per-snake eaten/died flags
// and a global won/draw result.
// Optional feature: define COLLISIONS_SWAP_EN to count head swaps as bumps.
module collisions_n #(
  parameter int N_SNAKES = 4,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int LEN_W    = 6,
  parameter int MAX_LEN  = 40,
  parameter int ID_W     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_SNAKES-1:0]       alive,
  input  logic [N_SNAKES-1:0]       moving,
  input  logic [N_SNAKES*X_W-1:0]   head_x,
  input  logic [N_SNAKES*Y_W-1:0]   head_y,
  input  logic [N_SNAKES*X_W-1:0]   tail_x,
  input  logic [N_SNAKES*Y_W-1:0]   tail_y,
  input  logic [N_SNAKES*X_W-1:0]   old_tail_x,
  input  logic [N_SNAKES*Y_W-1:0]   old_tail_y,
  input  logic [N_SNAKES*X_W-1:0]   old_head_x,
  input  logic [N_SNAKES*Y_W-1:0]   old_head_y,
  input  logic [N_SNAKES*LEN_W-1:0] length,
  output logic [X_W-1:0]            tile_rd_x,
  output logic [Y_W-1:0]            tile_rd_y,
  input  logic [1:0]                tile_kind,
  input  logic [ID_W-1:0]           tile_owner,
  output logic                      busy,
  output logic                      done,
  output logic [N_SNAKES-1:0]       eaten,
  output logic [N_SNAKES-1:0]       died,
  output logic                      won,
  output logic [ID_W-1:0]           winner,
  output logic                      draw
);

  // Snapshot arrays span every index an ID_W-wide owner can name, so slots
  // beyond N_SNAKES simply read as dead snakes.
  localparam int N_SLOTS = 1 << ID_W;
  localparam logic [1:0] K_WALL  = 2'd1;
  localparam logic [1:0] K_POINT = 2'd2;
  localparam logic [1:0] K_SNAKE = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_RESOLVE} state_t;
  state_t r_state, w_state_next;

  logic [ID_W-1:0]     r_idx, r_rd_idx;
  logic                r_rd_vld, r_skip;
  logic [N_SLOTS-1:0]  r_alive;
  logic [X_W-1:0]      r_hx  [N_SLOTS];
  logic [Y_W-1:0]      r_hy  [N_SLOTS];
  logic [X_W-1:0]      r_tx  [N_SLOTS];
  logic [Y_W-1:0]      r_ty  [N_SLOTS];
  logic [X_W-1:0]      r_otx [N_SLOTS];
  logic [Y_W-1:0]      r_oty [N_SLOTS];
  logic [LEN_W-1:0]    r_len [N_SLOTS];
`ifdef COLLISIONS_SWAP_EN
  logic [X_W-1:0]      r_ohx [N_SLOTS];
  logic [Y_W-1:0]      r_ohy [N_SLOTS];
`else
  logic                w_unused_old;
  assign w_unused_old = ^{old_head_x, old_head_y};
`endif

  logic [N_SNAKES-1:0] r_tile_died, r_eat_acc, w_geo_died;
  logic                w_accept, w_skip_in, w_tile_die, w_point;
  logic [N_SNAKES-1:0] w_died, w_eaten, w_surv;
  logic                w_won, w_draw;
  logic [ID_W-1:0]     w_winner, w_max_idx, w_surv_idx;
  logic [ID_W:0]       w_n_surv, w_n_max, w_n_alive;

  assign w_skip_in = |(alive & ~moving);
  assign w_accept  = (r_state == S_IDLE) && start;
  assign busy      = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: a stationary live snake short-circuits the scan.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = w_skip_in ? S_RESOLVE : S_SCAN;
      S_SCAN:    if (r_idx == ID_W'(N_SNAKES - 1)) w_state_next = S_DRAIN;
      S_DRAIN:   w_state_next = S_RESOLVE;
      S_RESOLVE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Capture the geometry of the step being judged; inputs may move on after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alive <= '0;
      r_skip  <= 1'b0;
      for (int k = 0; k < N_SLOTS; k++) begin
        r_hx[k]  <= '0;
        r_hy[k]  <= '0;
        r_tx[k]  <= '0;
        r_ty[k]  <= '0;
        r_otx[k] <= '0;
        r_oty[k] <= '0;
        r_len[k] <= '0;
`ifdef COLLISIONS_SWAP_EN
        r_ohx[k] <= '0;
        r_ohy[k] <= '0;
`endif
      end
    end else if (w_accept) begin
      r_alive <= N_SLOTS'(alive);
      r_skip  <= w_skip_in;
      for (int k = 0; k < N_SNAKES; k++) begin
        r_hx[k]  <= head_x[k*X_W +: X_W];
        r_hy[k]  <= head_y[k*Y_W +: Y_W];
        r_tx[k]  <= tail_x[k*X_W +: X_W];
        r_ty[k]  <= tail_y[k*Y_W +: Y_W];
        r_otx[k] <= old_tail_x[k*X_W +: X_W];
        r_oty[k] <= old_tail_y[k*Y_W +: Y_W];
        r_len[k] <= length[k*LEN_W +: LEN_W];
`ifdef COLLISIONS_SWAP_EN
        r_ohx[k] <= old_head_x[k*X_W +: X_W];
        r_ohy[k] <= old_head_y[k*Y_W +: Y_W];
`endif
      end
    end
  end

  // Scan index plus a one-cycle delayed copy that tags the returning tile data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_rd_idx <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= (r_state == S_SCAN);
      r_rd_idx <= r_idx;
      if (w_accept)                r_idx <= '0;
      else if (r_state == S_SCAN)  r_idx <= r_idx + ID_W'(1);
    end
  end

  // Map read address: the head of the snake being scanned, zero otherwise.
  always_comb begin
    tile_rd_x = '0;
    tile_rd_y = '0;
    if (r_state == S_SCAN) begin
      tile_rd_x = r_hx[r_idx];
      tile_rd_y = r_hy[r_idx];
    end
  end

  // Tile-dependent verdict; a body tile is harmless if its tail just vacated it.
  always_comb begin
    w_point    = (tile_kind == K_POINT);
    w_tile_die = (tile_kind == K_WALL);
    if (tile_kind == K_SNAKE && r_alive[tile_owner] &&
        !(r_hx[r_rd_idx] == r_otx[tile_owner] && r_hy[r_rd_idx] == r_oty[tile_owner]))
      w_tile_die = 1'b1;
  end

  // Collect per-snake tile verdicts as read data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tile_died <= '0;
      r_eat_acc   <= '0;
    end else if (w_accept) begin
      r_tile_died <= '0;
      r_eat_acc   <= '0;
    end else if (r_rd_vld) begin
      for (int k = 0; k < N_SNAKES; k++) begin
        if (r_rd_idx == ID_W'(k)) begin
          r_tile_died[k] <= w_tile_die;
          r_eat_acc[k]   <= w_point;
        end
      end
    end
  end

  // Geometry-only deaths: new tails, head-on bumps and optional head swaps.
  generate
    for (genvar gi = 0; gi < N_SNAKES; gi++) begin : g_geo
      logic w_hit;
      always_comb begin
        w_hit = 1'b0;
        for (int j = 0; j < N_SNAKES; j++) begin
          if (r_alive[j]) begin
            if (r_hx[gi] == r_tx[j] && r_hy[gi] == r_ty[j]) w_hit = 1'b1;
            if (j != gi && r_hx[gi] == r_hx[j] && r_hy[gi] == r_hy[j]) w_hit = 1'b1;
`ifdef COLLISIONS_SWAP_EN
            if (j != gi && r_hx[gi] == r_ohx[j] && r_hy[gi] == r_ohy[j] &&
                r_hx[j] == r_ohx[gi] && r_hy[j] == r_ohy[gi]) w_hit = 1'b1;
`endif
          end
        end
      end
      assign w_geo_died[gi] = w_hit;
    end
  endgenerate

  // Resolution: deaths, survivors, and the win/draw decision.
  always_comb begin
    w_died     = '0;
    w_eaten    = '0;
    w_won      = 1'b0;
    w_draw     = 1'b0;
    w_winner   = '0;
    w_max_idx  = '0;
    w_surv_idx = '0;
    w_n_surv   = '0;
    w_n_max    = '0;
    w_n_alive  = '0;
    if (!r_skip) begin
      w_died  = r_alive[N_SNAKES-1:0] & (r_tile_died | w_geo_died);
      w_eaten = r_alive[N_SNAKES-1:0] & r_eat_acc;
    end
    w_surv = r_alive[N_SNAKES-1:0] & ~w_died;
    for (int k = 0; k < N_SNAKES; k++) begin
      if (r_alive[k]) w_n_alive = w_n_alive + (ID_W+1)'(1);
      if (w_surv[k]) begin
        w_n_surv   = w_n_surv + (ID_W+1)'(1);
        w_surv_idx = ID_W'(k);
        if (r_len[k] == LEN_W'(MAX_LEN)) begin
          w_n_max   = w_n_max + (ID_W+1)'(1);
          w_max_idx = ID_W'(k);
        end
      end
    end
    if (!r_skip) begin
      if ((|w_died) && w_n_surv == '0) begin
        w_draw = 1'b1;
      end else if (w_n_max == (ID_W+1)'(1)) begin
        w_won    = 1'b1;
        w_winner = w_max_idx;
      end else if (w_n_max > (ID_W+1)'(1)) begin
        w_draw = 1'b1;
      end else if (w_n_alive >= (ID_W+1)'(2) && w_n_surv == (ID_W+1)'(1)) begin
        w_won    = 1'b1;
        w_winner = w_surv_idx;
      end
    end
  end

  // Result registers, loaded at the end of RESOLVE together with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      eaten  <= '0;
      died   <= '0;
      won    <= 1'b0;
      winner <= '0;
      draw   <= 1'b0;
    end else begin
      done <= (r_state == S_RESOLVE);
      if (r_state == S_RESOLVE) begin
        eaten  <= w_eaten;
        died   <= w_died;
        won    <= w_won;
        winner <= w_winner;
        draw   <= w_draw;
      end
    end
  end

endmodule

// File: tb/tb_collisions_n.sv
// Randomised and directed bench for collisions_n against a behavioural model.
module tb_collisions_n;
  localparam int N = 4, X_W = 5, Y_W = 5, LEN_W = 6, MAX_LEN = 40, ID_W = 3;

  logic clk = 1'b0;
  logic rst, start;
  logic [N-1:0] alive, moving;
  logic [N*X_W-1:0] head_x, tail_x, old_tail_x, old_head_x;
  logic [N*Y_W-1:0] head_y, tail_y, old_tail_y, old_head_y;
  logic [N*LEN_W-1:0] length;
  logic [X_W-1:0] tile_rd_x;
  logic [Y_W-1:0] tile_rd_y;
  logic [1:0] tile_kind;
  logic [ID_W-1:0] tile_owner;
  logic busy, done, won, draw;
  logic [N-1:0] eaten, died;
  logic [ID_W-1:0] winner;

  always #5 clk = ~clk;

  collisions_n #(.N_SNAKES(N), .X_W(X_W), .Y_W(Y_W), .LEN_W(LEN_W),
                 .MAX_LEN(MAX_LEN), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .start(start), .alive(alive), .moving(moving),
    .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
    .old_tail_x(old_tail_x), .old_tail_y(old_tail_y),
    .old_head_x(old_head_x), .old_head_y(old_head_y), .length(length),
    .tile_rd_x(tile_rd_x), .tile_rd_y(tile_rd_y), .tile_kind(tile_kind),
    .tile_owner(tile_owner), .busy(busy), .done(done), .eaten(eaten),
    .died(died), .won(won), .winner(winner), .draw(draw)
  );

  // Current map with a registered read port.
  logic [1:0]      map_kind  [0:31][0:31];
  logic [ID_W-1:0] map_owner [0:31][0:31];
  always @(posedge clk) begin
    tile_kind  <= map_kind[tile_rd_x][tile_rd_y];
    tile_owner <= map_owner[tile_rd_x][tile_rd_y];
  end

  // Scenario description for the model.
  logic [N-1:0] m_alive, m_moving;
  int hx[N], hy[N], tx[N], ty[N], otx[N], oty[N], ohx[N], ohy[N], len[N];

  int checks = 0, errors = 0, txn = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_map();
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++) begin
        map_kind[x][y]  = 2'd0;
        map_owner[x][y] = '0;
      end
  endtask

  task automatic base_scene();
    clear_map();
    m_alive  = '1;
    m_moving = '1;
    for (int i = 0; i < N; i++) begin
      hx[i] = i + 1;  hy[i] = i + 1;
      tx[i] = i + 1;  ty[i] = 10;
      otx[i] = i + 1; oty[i] = 11;
      ohx[i] = i + 1; ohy[i] = 0;
      len[i] = 5;
    end
  endtask

  task automatic drive_inputs();
    alive  = m_alive;
    moving = m_moving;
    for (int i = 0; i < N; i++) begin
      head_x[i*X_W +: X_W]     = X_W'(hx[i]);
      head_y[i*Y_W +: Y_W]     = Y_W'(hy[i]);
      tail_x[i*X_W +: X_W]     = X_W'(tx[i]);
      tail_y[i*Y_W +: Y_W]     = Y_W'(ty[i]);
      old_tail_x[i*X_W +: X_W] = X_W'(otx[i]);
      old_tail_y[i*Y_W +: Y_W] = Y_W'(oty[i]);
      old_head_x[i*X_W +: X_W] = X_W'(ohx[i]);
      old_head_y[i*Y_W +: Y_W] = Y_W'(ohy[i]);
      length[i*LEN_W +: LEN_W] = LEN_W'(len[i]);
    end
  endtask

  task automatic scramble_inputs();
    alive = N'($urandom); moving = N'($urandom);
    head_x = N*X_W'($urandom); head_y = N*Y_W'($urandom);
    tail_x = N*X_W'($urandom); tail_y = N*Y_W'($urandom);
    old_tail_x = N*X_W'($urandom); old_tail_y = N*Y_W'($urandom);
    old_head_x = N*X_W'($urandom); old_head_y = N*Y_W'($urandom);
    length = N*LEN_W'($urandom);
  endtask

  // Game rules applied directly to the scenario arrays.
  task automatic model(output logic [N-1:0] e_eaten, output logic [N-1:0] e_died,
                       output logic e_won, output int e_winner, output logic e_draw,
                       output logic e_skip);
    int n_alive, n_surv, n_max, max_i, surv_i, kind, own;
    logic d;
    e_eaten = '0; e_died = '0; e_won = 1'b0; e_winner = 0; e_draw = 1'b0;
    e_skip = |(m_alive & ~m_moving);
    if (e_skip) return;
    for (int i = 0; i < N; i++) begin
      if (!m_alive[i]) continue;
      kind = int'(map_kind[hx[i]][hy[i]]);
      own  = int'(map_owner[hx[i]][hy[i]]);
      e_eaten[i] = (kind == 2);
      d = (kind == 1);
      if (kind == 3 && own < N && m_alive[own] && !(hx[i] == otx[own] && hy[i] == oty[own]))
        d = 1'b1;
      for (int j = 0; j < N; j++) begin
        if (!m_alive[j]) continue;
        if (hx[i] == tx[j] && hy[i] == ty[j]) d = 1'b1;
        if (j != i && hx[i] == hx[j] && hy[i] == hy[j]) d = 1'b1;
`ifdef COLLISIONS_SWAP_EN
        if (j != i && hx[i] == ohx[j] && hy[i] == ohy[j] && hx[j] == ohx[i] && hy[j] == ohy[i])
          d = 1'b1;
`endif
      end
      e_died[i] = d;
    end
    n_alive = 0; n_surv = 0; n_max = 0; max_i = 0; surv_i = 0;
    for (int i = 0; i < N; i++) begin
      if (m_alive[i]) n_alive++;
      if (m_alive[i] && !e_died[i]) begin
        n_surv++; surv_i = i;
        if (len[i] == MAX_LEN) begin n_max++; max_i = i; end
      end
    end
    if (e_died != 0 && n_surv == 0) e_draw = 1'b1;
    else if (n_max == 1) begin e_won = 1'b1; e_winner = max_i; end
    else if (n_max > 1) e_draw = 1'b1;
    else if (n_alive >= 2 && n_surv == 1) begin e_won = 1'b1; e_winner = surv_i; end
  endtask

  task automatic run_txn(string name, bit extra_start);
    logic [N-1:0] e_eaten, e_died;
    logic e_won, e_draw, e_skip;
    int e_winner, cyc, e_lat;
    model(e_eaten, e_died, e_won, e_winner, e_draw, e_skip);
    e_lat = e_skip ? 1 : N + 2;
    @(negedge clk);
    drive_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = extra_start;
    scramble_inputs();
    check_val({name, ":busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check_val({name, ":latency"}, cyc, e_lat);
    check_val({name, ":busy_end"}, 32'(busy), 32'd0);
    check_val({name, ":eaten"}, 32'(eaten), 32'(e_eaten));
    check_val({name, ":died"}, 32'(died), 32'(e_died));
    check_val({name, ":won"}, 32'(won), 32'(e_won));
    check_val({name, ":draw"}, 32'(draw), 32'(e_draw));
    if (e_won) check_val({name, ":winner"}, 32'(winner), e_winner);
    $display("txn %0d %s lat=%0d eaten=%b died=%b won=%b winner=%0d draw=%b",
             txn, name, cyc, eaten, died, won, winner, draw);
    txn++;
    @(posedge clk); #1;
    check_val({name, ":done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0;
    base_scene();
    drive_inputs();
    #1;
    check_val("reset:busy", 32'(busy), 0);
    check_val("reset:done", 32'(done), 0);
    check_val("reset:outs", 32'({eaten, died, won, winner, draw}), 0);
    check_val("reset:rd_addr", 32'({tile_rd_x, tile_rd_y}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    base_scene();
    run_txn("all_empty", 1'b0);

    base_scene();
    map_kind[2][2] = 2'd1;
    run_txn("wall_s1", 1'b0);

    // Reset in the middle of a scan clears the held results and aborts the step.
    base_scene();
    @(negedge clk);
    drive_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("rst_scan:died", 32'(died), 0);
    check_val("rst_scan:busy", 32'(busy), 0);
    check_val("rst_scan:outs", 32'({eaten, won, winner, draw, done}), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < N + 6; c++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check_val("rst_scan:no_done", seen, 0);
    $display("txn %0d reset_during_scan done_seen=%0d", txn, seen);
    txn++;

    base_scene();
    m_alive = 4'b0101;
    hx[0] = 5; hy[0] = 5; hx[2] = 5; hy[2] = 5;
    run_txn("shared_head", 1'b0);

    base_scene();
    m_alive = 4'b1001;
    hx[3] = 7; hy[3] = 7;
    map_kind[7][7] = 2'd3; map_owner[7][7] = 3'd0;
    otx[0] = 7; oty[0] = 7;
    run_txn("body_on_old_tail", 1'b0);
    otx[0] = 9; oty[0] = 9;
    run_txn("body_hit", 1'b0);

    base_scene();
    len[2] = MAX_LEN;
    map_kind[3][3] = 2'd2;
    run_txn("max_len_win", 1'b0);
    m_moving = 4'b1011;
    run_txn("not_moving", 1'b0);

    base_scene();
    ohx[0] = 3; ohy[0] = 4; hx[0] = 3; hy[0] = 5;
    ohx[1] = 3; ohy[1] = 5; hx[1] = 3; hy[1] = 4;
    run_txn("head_swap", 1'b0);

    for (int t = 0; t < 150; t++) begin
      clear_map();
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++) begin
          map_kind[x][y]  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
          map_owner[x][y] = ID_W'($urandom_range(0, N - 1));
        end
      m_alive  = N'($urandom);
      m_moving = ($urandom_range(0, 5) == 0) ? N'($urandom) : '1;
      for (int i = 0; i < N; i++) begin
        hx[i] = $urandom_range(0, 5);  hy[i] = $urandom_range(0, 5);
        tx[i] = $urandom_range(0, 7);  ty[i] = $urandom_range(0, 7);
        otx[i] = $urandom_range(0, 7); oty[i] = $urandom_range(0, 7);
        ohx[i] = $urandom_range(0, 7); ohy[i] = $urandom_range(0, 7);
        len[i] = ($urandom_range(0, 2) == 0) ? MAX_LEN : $urandom_range(0, 39);
      end
      if ($urandom_range(0, 5) == 0) begin
        ohx[0] = hx[1]; ohy[0] = hy[1];
        ohx[1] = hx[0]; ohy[1] = hy[0];
      end
      run_txn("random", $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
